// File: rtl/stack_op_sequencer_if.sv
// Instruction-source and stack-side signals of the stack-op sequencer.
// master = instruction source / stack environment side, slave = sequencer.
interface stack_op_sequencer_if #(
  parameter int DATA_W = 4,
  parameter int CNT_W  = 5
);
  logic              instr_valid;
  logic              instr_ready;
  logic [3+DATA_W:0] instr;
  logic              stk_push;
  logic              stk_pop;
  logic [DATA_W-1:0] stk_wdata;
  logic [DATA_W-1:0] stk_rdata;
  logic [CNT_W-1:0]  depth;
  logic              op_done;
  logic              err_flow;
  logic              err_illegal;

  modport master (
    output instr_valid, instr, stk_rdata,
    input  instr_ready, stk_push, stk_pop, stk_wdata, depth,
           op_done, err_flow, err_illegal
  );

  modport slave (
    input  instr_valid, instr, stk_rdata,
    output instr_ready, stk_push, stk_pop, stk_wdata, depth,
           op_done, err_flow, err_illegal
  );
endinterface

// File: rtl/stack_op_sequencer.sv
// Decodes an 8-bit stack-machine instruction stream into push/pop strobes for a
// DEPTH-entry stack. Define STACK_OP_SAT_ARITH_EN for saturating ADD/SUB.
module stack_op_sequencer #(
  parameter int DEPTH  = 16,
  parameter int DATA_W = 4,
  parameter int CNT_W  = 5
) (
  input logic                  clk_i,
  input logic                  rst_ni,
  stack_op_sequencer_if.slave  bus
);

  typedef enum logic [2:0] {IDLE, ISSUE, POP_A, POP_B, PUSH_R, PUSH_2} state_e;
  typedef enum logic [3:0] {
    OP_NOP = 4'd0, OP_PUSH = 4'd1, OP_POP = 4'd2, OP_DUP = 4'd3,
    OP_ADD = 4'd4, OP_SUB = 4'd5, OP_SWAP = 4'd6
  } op_e;

  state_e            state_q, state_d;
  op_e               op_q, op_d;
  logic [DATA_W-1:0] a_q, a_d, b_q, b_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [CNT_W-1:0]  depth_q, depth_d;
  logic              push_q, push_d, pop_q, pop_d;
  logic              done_q, done_d, flow_q, flow_d, ill_q, ill_d;

  op_e               opcode;
  logic [DATA_W-1:0] imm;
  logic              is_empty, is_full, lt_two;

  assign opcode   = op_e'(bus.instr[DATA_W +: 4]);
  assign imm      = bus.instr[DATA_W-1:0];
  assign is_empty = (depth_q == '0);
  assign is_full  = (depth_q >= CNT_W'(DEPTH));
  assign lt_two   = (depth_q < CNT_W'(2));

  // Result = B op A, where A is the old top and B the entry beneath it.
  function automatic logic [DATA_W-1:0] alu(input logic is_sub,
                                            input logic [DATA_W-1:0] b,
                                            input logic [DATA_W-1:0] a);
`ifdef STACK_OP_SAT_ARITH_EN
    logic [DATA_W:0] sum;
    sum = {1'b0, b} + {1'b0, a};
    if (is_sub) return (b < a) ? '0 : b - a;
    return sum[DATA_W] ? '1 : sum[DATA_W-1:0];
`else
    return is_sub ? b - a : b + a;
`endif
  endfunction

  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    state_d = state_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    wdata_d = wdata_q;
    push_d  = 1'b0;
    pop_d   = 1'b0;
    done_d  = 1'b0;
    flow_d  = 1'b0;
    ill_d   = 1'b0;
    // Depth follows the strobes on the same edge the stack applies them.
    depth_d = depth_q + CNT_W'(push_q) - CNT_W'(pop_q);

    unique case (state_q)
      IDLE: if (bus.instr_valid) begin
        op_d    = opcode;
        state_d = ISSUE;
        case (opcode)
          OP_NOP:  done_d = 1'b1;
          OP_PUSH: if (is_full) flow_d = 1'b1;
                   else begin push_d = 1'b1; wdata_d = imm; done_d = 1'b1; end
          OP_POP:  if (is_empty) flow_d = 1'b1;
                   else begin pop_d = 1'b1; done_d = 1'b1; end
          OP_DUP:  if (is_empty || is_full) flow_d = 1'b1;
                   else begin push_d = 1'b1; wdata_d = bus.stk_rdata; done_d = 1'b1; end
          OP_ADD, OP_SUB, OP_SWAP:
                   if (lt_two) flow_d = 1'b1;
                   else begin pop_d = 1'b1; state_d = POP_A; end
          default: ill_d = 1'b1;
        endcase
      end
      ISSUE: state_d = IDLE;
      POP_A: begin
        a_d     = bus.stk_rdata;
        pop_d   = 1'b1;
        state_d = POP_B;
      end
      POP_B: begin
        b_d     = bus.stk_rdata;
        push_d  = 1'b1;
        state_d = PUSH_R;
        if (op_q == OP_SWAP) begin
          wdata_d = a_q;
        end else begin
          wdata_d = alu(op_q == OP_SUB, bus.stk_rdata, a_q);
          done_d  = 1'b1;
        end
      end
      PUSH_R: if (op_q == OP_SWAP) begin
        push_d  = 1'b1;
        wdata_d = b_q;
        done_d  = 1'b1;
        state_d = PUSH_2;
      end else begin
        state_d = IDLE;
      end
      PUSH_2: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      op_q    <= OP_NOP;
      a_q     <= '0;
      b_q     <= '0;
      wdata_q <= '0;
      depth_q <= '0;
      push_q  <= 1'b0;
      pop_q   <= 1'b0;
      done_q  <= 1'b0;
      flow_q  <= 1'b0;
      ill_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      wdata_q <= wdata_d;
      depth_q <= depth_d;
      push_q  <= push_d;
      pop_q   <= pop_d;
      done_q  <= done_d;
      flow_q  <= flow_d;
      ill_q   <= ill_d;
    end
  end

  assign bus.instr_ready = (state_q == IDLE);
  assign bus.stk_push    = push_q;
  assign bus.stk_pop     = pop_q;
  assign bus.stk_wdata   = wdata_q;
  assign bus.depth       = depth_q;
  assign bus.op_done     = done_q;
  assign bus.err_flow    = flow_q;
  assign bus.err_illegal = ill_q;

endmodule
